// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters (grant, hold operands ALU_LAT cycles, capture, done pulse).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [5:0]         opc,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [1:0]         cin,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic [WIDTH-1:0]   res_w,
    output logic               res_zer,
    output logic               res_neg,
    output logic               busy,
    output logic [2:0]         alu_opc,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    input  logic [WIDTH-1:0]   alu_w,
    input  logic               alu_zer,
    input  logic               alu_neg
);
    localparam int CW = $clog2(ALU_LAT + 1) + 1;

    generate
        if (ALU_LAT < 1) begin : g_lat_check
            $error("alu_share_arbiter: ALU_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d, done_q, done_d;
    logic [WIDTH-1:0]  res_w_q, res_w_d;
    logic              res_zer_q, res_zer_d, res_neg_q, res_neg_d;
    logic              busy_q, busy_d;
    logic [2:0]        alu_opc_q, alu_opc_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic              alu_cin_q, alu_cin_d;
    logic              owner_q, owner_d, rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              win;

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = ~req[0];
`else
        win = (&req) ? rr_q : req[1];
`endif
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        res_w_d   = res_w_q;
        res_zer_d = res_zer_q;
        res_neg_d = res_neg_q;
        alu_opc_d = alu_opc_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d   = win;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    alu_opc_d = win ? opc[5:3] : opc[2:0];
                    alu_a_d   = win ? a[2*WIDTH-1:WIDTH] : a[WIDTH-1:0];
                    alu_b_d   = win ? b[2*WIDTH-1:WIDTH] : b[WIDTH-1:0];
                    alu_cin_d = win ? cin[1] : cin[0];
                    cnt_d     = CW'(ALU_LAT);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // Flags come straight from the ALU; the done pulse lines up with the capture.
                if (cnt_q == CW'(1)) begin
                    res_w_d         = alu_w;
                    res_zer_d       = alu_zer;
                    res_neg_d       = alu_neg;
                    done_d[owner_q] = 1'b1;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            res_w_q   <= '0;
            res_zer_q <= 1'b0;
            res_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            alu_opc_q <= 3'd0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            res_w_q   <= res_w_d;
            res_zer_q <= res_zer_d;
            res_neg_q <= res_neg_d;
            busy_q    <= busy_d;
            alu_opc_q <= alu_opc_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign res_w   = res_w_q;
    assign res_zer = res_zer_q;
    assign res_neg = res_neg_q;
    assign busy    = busy_q;
    assign alu_opc = alu_opc_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_cin = alu_cin_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: ALU_LAT=1 instance with a result scoreboard, ALU_LAT=3 instance for spacing.
module tb_alu_share_arbiter;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00, req3 = 2'b00;
    logic [5:0]  opc = '0;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  cin = '0;

    logic [1:0]  gnt, done, gnt3, done3;
    logic [15:0] res_w, res_w3, alu_a, alu_b, alu_w, alu_a3, alu_b3, alu_w3;
    logic        res_zer, res_neg, busy, alu_cin, alu_zer, alu_neg;
    logic        res_zer3, res_neg3, busy3, alu_cin3, alu_zer3, alu_neg3;
    logic [2:0]  alu_opc, alu_opc3;

    always #5 clk = ~clk;

    // Reference ALU: returns {neg, zer, w}.
    function automatic logic [17:0] alu_ref(input logic [2:0] o, input logic [15:0] x,
                                            input logic [15:0] y, input logic c);
        logic [15:0] w;
        w = (o == 3'd0) ? x + y + {15'd0, c} : x - y;
        return {w[15], (w == 16'd0), w};
    endfunction

    assign {alu_neg, alu_zer, alu_w}    = alu_ref(alu_opc, alu_a, alu_b, alu_cin);
    assign {alu_neg3, alu_zer3, alu_w3} = alu_ref(alu_opc3, alu_a3, alu_b3, alu_cin3);

    alu_share_arbiter #(.WIDTH(16), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .opc(opc), .a(a), .b(b), .cin(cin),
        .gnt(gnt), .done(done), .res_w(res_w), .res_zer(res_zer), .res_neg(res_neg),
        .busy(busy), .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg));

    alu_share_arbiter #(.WIDTH(16), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .opc(opc), .a(a), .b(b), .cin(cin),
        .gnt(gnt3), .done(done3), .res_w(res_w3), .res_zer(res_zer3), .res_neg(res_neg3),
        .busy(busy3), .alu_opc(alu_opc3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3),
        .alu_w(alu_w3), .alu_zer(alu_zer3), .alu_neg(alu_neg3));

    typedef struct {
        logic        who;
        logic [15:0] w;
        logic        zer;
        logic        neg;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0;
    int   cyc = 0, gcyc = 0;
    int   gnt1_cnt = 0, done1_cnt = 0;
    logic exp_rr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input logic [1:0] r);
        if (FIXED) return ~r[0];
        return (&r) ? exp_rr : r[1];
    endfunction

    task automatic set_op(input int i, input logic [2:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic c);
        opc[3*i +: 3] = o;
        a[16*i +: 16] = x;
        b[16*i +: 16] = y;
        cin[i]        = c;
    endtask

    task automatic push_exp(input logic who);
        logic [17:0] r;
        exp_t e;
        r = who ? alu_ref(opc[5:3], a[31:16], b[31:16], cin[1])
                : alu_ref(opc[2:0], a[15:0], b[15:0], cin[0]);
        e.who = who; e.w = r[15:0]; e.zer = r[16]; e.neg = r[17];
        q.push_back(e);
        exp_rr = ~who;
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] want);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else begin
            gcyc = cyc;
            chk(tag, {30'd0, gnt}, {30'd0, want});
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) chk({tag, "_drain_timeout"}, q.size(), 0);
        @(negedge clk);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_single(input string tag, input int i, input logic [2:0] o,
                              input logic [15:0] x, input logic [15:0] y, input logic c);
        @(negedge clk);
        set_op(i, o, x, y, c);
        req[i] = 1'b1;
        push_exp(pick(req));
        wait_gnt({tag, "_gnt"}, (i == 1) ? 2'b10 : 2'b01);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        req = 2'b00;
        drain(tag);
    endtask

    // Scoreboard side: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (gnt[1]) gnt1_cnt++;
            if (done[1]) done1_cnt++;
            if (done != 2'b00) begin
                if (q.size() == 0) chk("done_unexpected", {30'd0, done}, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("done_who", {30'd0, done}, e.who ? 32'd2 : 32'd1);
                    chk("res_w", {16'd0, res_w}, {16'd0, e.w});
                    chk("res_zer", {31'd0, res_zer}, {31'd0, e.zer});
                    chk("res_neg", {31'd0, res_neg}, {31'd0, e.neg});
                    chk("gnt_to_done", cyc - gcyc, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d1, g1, prev;
        logic [17:0] r3;
        logic [15:0] ea;
        bit seen;

        #1;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_w", {16'd0, res_w}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_opc", {29'd0, alu_opc}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requests with directed results.
        run_single("t1", 0, 3'd0, 16'h0003, 16'h0004, 1'b1);
        chk("t1_w", {16'd0, res_w}, 32'h0008);
        chk("t1_zn", {30'd0, res_zer, res_neg}, 32'd0);
        run_single("t2a", 0, 3'd1, 16'd5, 16'd5, 1'b0);
        chk("t2a_w", {16'd0, res_w}, 32'd0);
        chk("t2a_zer", {31'd0, res_zer}, 32'd1);
        run_single("t2b", 1, 3'd1, 16'd3, 16'd5, 1'b0);
        chk("t2b_w", {16'd0, res_w}, 32'h0000FFFE);
        chk("t2b_zn", {30'd0, res_zer, res_neg}, 32'd1);

        // Both requesters held for 8 operations.
        @(negedge clk);
        set_op(0, 3'd0, 16'd10, 16'd20, 1'b0);
        set_op(1, 3'd1, 16'd100, 16'd1, 1'b0);
        req = 2'b11;
        d1 = done1_cnt;
        for (int n = 0; n < 8; n++) begin
            logic w;
            w = pick(req);
            push_exp(w);
            wait_gnt("t3_gnt", w ? 2'b10 : 2'b01);
        end
        req = 2'b00;
        drain("t3");
        chk("t3_done1_count", done1_cnt - d1, FIXED ? 32'd0 : 32'd4);

        // Reset while in EXEC aborts the operation.
        @(negedge clk);
        set_op(0, 3'd0, 16'd7, 16'd1, 1'b0);
        req = 2'b01;
        wait_gnt("t4_gnt", 2'b01);
        req = 2'b00;
        rst = 1'b1;
        #1;
        chk("t4_gnt", {30'd0, gnt}, 32'd0);
        chk("t4_done", {30'd0, done}, 32'd0);
        chk("t4_res_w", {16'd0, res_w}, 32'd0);
        chk("t4_alu_a", {16'd0, alu_a}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        exp_rr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_single("t4_after", 0, 3'd0, 16'h1234, 16'h0001, 1'b1);

        // Short req[1] pulse while requester 0 owns the ALU is withdrawn.
        g1 = gnt1_cnt;
        d1 = done1_cnt;
        @(negedge clk);
        set_op(0, 3'd1, 16'd9, 16'd4, 1'b0);
        req = 2'b01;
        push_exp(1'b0);
        wait_gnt("t5_gnt", 2'b01);
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        drain("t5");
        repeat (3) @(negedge clk);
        chk("t5_gnt1", gnt1_cnt - g1, 32'd0);
        chk("t5_done1", done1_cnt - d1, 32'd0);

        // ALU_LAT=3: spacing and operand stability.
        @(negedge clk);
        set_op(0, 3'd0, 16'd100, 16'd1, 1'b0);
        req3 = 2'b01;
        prev = 0;
        for (int n = 0; n < 3; n++) begin
            r3 = alu_ref(3'd0, a[15:0], b[15:0], cin[0]);
            ea = a[15:0];
            seen = 1'b0;
            for (int k = 0; k < 12 && !seen; k++) begin
                @(negedge clk);
                if (gnt3 != 2'b00) seen = 1'b1;
            end
            if (!seen) chk("t6_gnt_timeout", 32'd0, 32'd1);
            chk("t6_gnt", {30'd0, gnt3}, 32'd1);
            if (n > 0) chk("t6_period", cyc - prev, 32'd5);
            prev = cyc;
            set_op(0, 3'd0, a[15:0] + 16'd11, 16'd2, 1'b1);
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                chk("t6_alu_a_stable", {16'd0, alu_a3}, {16'd0, ea});
                if (k < 3) chk("t6_done_early", {30'd0, done3}, 32'd0);
                else begin
                    chk("t6_done", {30'd0, done3}, 32'd1);
                    chk("t6_res_w", {16'd0, res_w3}, {16'd0, r3[15:0]});
                end
            end
        end
        req3 = 2'b00;
        repeat (4) @(negedge clk);
        chk("t6_busy_after", {31'd0, busy3}, 32'd0);
        chk("sb_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
